// File: rtl/counter_run_ctrl.sv
// rtl/counter_run_ctrl.sv - run sequencer driving a downstream counter's clear and enable pins
//
// Purpose: on an accepted start, clear the downstream counter for one cycle,
// wait a latched arm delay, hold enable for a latched run length, then pulse
// done and bump a saturating completed-run count. Abort returns to IDLE
// without a done pulse.
//
// Ports:
//   clock_i       system clock, rising edge
//   reset_i       synchronous reset, active-high
//   start_i       run request, sampled only in IDLE
//   abort_i       cancel, effective in CLEAR, ARM and RUN
//   run_len_i     enable-cycle count, latched on accepted start
//   arm_dly_i     clear-to-enable gap in cycles, latched on accepted start
//   counter_clr_o downstream counter reset (CLEAR)
//   enable_o      downstream counter enable (RUN)
//   busy_o        high in every state except IDLE
//   done_o        one-cycle pulse in DONE
//   runs_done_o   completed runs, saturating

module counter_run_ctrl #(
  parameter int LEN_W  = 8,
  parameter int DLY_W  = 4,
  parameter int RUNS_W = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [LEN_W-1:0]  run_len_i,
  input  logic [DLY_W-1:0]  arm_dly_i,
  output logic              counter_clr_o,
  output logic              enable_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [RUNS_W-1:0] runs_done_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [DLY_W-1:0]  DLY_ONE  = DLY_W'(1);
  localparam logic [RUNS_W-1:0] RUNS_ONE = RUNS_W'(1);
  localparam logic [RUNS_W-1:0] RUNS_MAX = '1;

  logic [2:0]        state_q, state_d;
  // len_q/dly_q hold the latched values and double as the down-counters:
  // dly_q counts down through ARM, len_q through RUN.
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [RUNS_W-1:0] runs_done_q;
  logic              counter_clr_q, enable_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    dly_d   = dly_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          len_d   = run_len_i;
          dly_d   = arm_dly_i;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (abort_i)                state_d = ST_IDLE;
        else if (len_q == '0)       state_d = ST_DONE;
        else if (dly_q != '0)       state_d = ST_ARM;
        else                        state_d = ST_RUN;
      end
      ST_ARM: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          // Entered only with dly_q >= 1; the cycle that sees 1 is the last ARM cycle.
          if (dly_q <= DLY_ONE) state_d = ST_RUN;
          if (dly_q != '0)      dly_d   = dly_q - DLY_ONE;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          if (len_q <= LEN_ONE) state_d = ST_DONE;
          if (len_q != '0)      len_d   = len_q - LEN_ONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q
  // while leaving no combinational path from any input to any output.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      dly_q         <= '0;
      runs_done_q   <= '0;
      counter_clr_q <= 1'b0;
      enable_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      dly_q         <= dly_d;
      counter_clr_q <= (state_d == ST_CLEAR);
      enable_q      <= (state_d == ST_RUN);
      busy_q        <= (state_d != ST_IDLE);
      done_q        <= (state_d == ST_DONE);
      if (state_d == ST_DONE && runs_done_q != RUNS_MAX)
        runs_done_q <= runs_done_q + RUNS_ONE;
    end
  end

  assign counter_clr_o = counter_clr_q;
  assign enable_o      = enable_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign runs_done_o   = runs_done_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb/tb_counter_run_ctrl.sv - directed self-checking bench for counter_run_ctrl

module tb_counter_run_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] run_len = 8'd0;
  logic [3:0] arm_dly = 4'd0;
  logic       counter_clr, enable, busy, done;
  logic [7:0] runs_done;
  logic [3:0] first_counter;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  counter_run_ctrl #(.LEN_W(8), .DLY_W(4), .RUNS_W(8)) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .start_i      (start),
    .abort_i      (abort),
    .run_len_i    (run_len),
    .arm_dly_i    (arm_dly),
    .counter_clr_o(counter_clr),
    .enable_o     (enable),
    .busy_o       (busy),
    .done_o       (done),
    .runs_done_o  (runs_done)
  );

  // Downstream 4-bit enable counter that the sequencer drives.
  always_ff @(posedge clock) begin
    if (counter_clr)  first_counter <= 4'h0;
    else if (enable)  first_counter <= first_counter + 4'h1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one start and observe until busy drops. Cycle 0 is the cycle after
  // the edge that sampled start. Inputs are scrambled after start to show
  // only latched values matter.
  task automatic do_run(input logic [7:0] len, input logic [3:0] dly,
                        output int clr_n, output int en_n, output int done_n,
                        output int en_first, output int done_at, output bit tmo);
    int k;
    run_len = len; arm_dly = dly; start = 1'b1;
    step();
    start = 1'b0; run_len = 8'hC3; arm_dly = 4'hF;
    clr_n = 0; en_n = 0; done_n = 0; en_first = -1; done_at = -1; k = 0;
    while (busy && k < 200) begin
      if (counter_clr) clr_n++;
      if (enable) begin
        if (en_first < 0) en_first = k;
        en_n++;
      end
      if (done) begin
        done_n++;
        done_at = k;
      end
      step();
      k++;
    end
    tmo = (k >= 200);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; run_len = 8'd5;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({counter_clr, enable, busy, done, runs_done} !== 12'h000) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: got clr=%b en=%b busy=%b done=%b runs=%h, want all 0",
                 i, counter_clr, enable, busy, done, runs_done);
      end
    end
    start = 1'b0; reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || counter_clr !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_idle: got busy=%b clr=%b, want 0 0", busy, counter_clr);
    end
  endtask

  task automatic test_basic_run();
    int c, e, d, ef, da; bit t;
    do_run(8'd10, 4'd0, c, e, d, ef, da, t);
    checks++;
    if (t || c != 1 || e != 10 || d != 1 || ef != 1 || da != 11) begin
      fails++;
      $display("FAIL basic_run: got tmo=%0d clr=%0d en=%0d done=%0d en_first=%0d done_at=%0d, want 0 1 10 1 1 11",
               t, c, e, d, ef, da);
    end
    checks++;
    if (first_counter !== 4'hA) begin
      fails++;
      $display("FAIL basic_counter: got %h, want a", first_counter);
    end
    checks++;
    if (runs_done !== 8'd1) begin
      fails++;
      $display("FAIL basic_runs_done: got %0d, want 1", runs_done);
    end
  endtask

  task automatic test_arm_delay();
    int c, e, d, ef, da; bit t;
    do_run(8'd20, 4'd3, c, e, d, ef, da, t);
    checks++;
    if (t || c != 1 || e != 20 || d != 1 || ef != 4 || da != 24) begin
      fails++;
      $display("FAIL arm_run: got tmo=%0d clr=%0d en=%0d done=%0d en_first=%0d done_at=%0d, want 0 1 20 1 4 24",
               t, c, e, d, ef, da);
    end
    checks++;
    if (first_counter !== 4'h4) begin
      fails++;
      $display("FAIL arm_counter: got %h, want 4", first_counter);
    end
    checks++;
    if (runs_done !== 8'd2) begin
      fails++;
      $display("FAIL arm_runs_done: got %0d, want 2", runs_done);
    end
  endtask

  task automatic test_abort();
    int en_n = 0, done_n = 0;
    run_len = 8'd12; arm_dly = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (enable) en_n++;
      if (en_n == 5) abort = 1'b1;
      step();
      if (abort) break;
    end
    abort = 1'b0;
    checks++;
    if (enable !== 1'b0 || busy !== 1'b0 || counter_clr !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: got en=%b busy=%b clr=%b, want 0 0 0", enable, busy, counter_clr);
    end
    for (int k = 0; k < 15; k++) begin
      if (done || enable) done_n++;
      step();
    end
    checks++;
    if (done_n != 0 || first_counter !== 4'h5 || runs_done !== 8'd2) begin
      fails++;
      $display("FAIL abort_after: got done/en=%0d counter=%h runs=%0d, want 0 5 2",
               done_n, first_counter, runs_done);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_in_idle: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_zero_len_and_ignore();
    int c, e, d, ef, da, k; bit t;
    do_run(8'd0, 4'd2, c, e, d, ef, da, t);
    checks++;
    if (t || c != 1 || e != 0 || d != 1 || da != 1 || runs_done !== 8'd3) begin
      fails++;
      $display("FAIL zero_len: got tmo=%0d clr=%0d en=%0d done=%0d done_at=%0d runs=%0d, want 0 1 0 1 1 3",
               t, c, e, d, da, runs_done);
    end
    // Start pulses mid-run and during DONE must not extend or requeue.
    run_len = 8'd5; arm_dly = 4'd0; start = 1'b1;
    step();
    start = 1'b0; e = 0; d = 0; k = 0;
    while (busy && k < 50) begin
      if (enable) e++;
      if (done) d++;
      start = (k == 2) || done;
      step();
      start = 1'b0;
      k++;
    end
    checks++;
    if (k >= 50 || e != 5 || d != 1 || runs_done !== 8'd4) begin
      fails++;
      $display("FAIL start_ignored: got cycles=%0d en=%0d done=%0d runs=%0d, want <50 5 1 4", k, e, d, runs_done);
    end
    c = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy) c++;
      step();
    end
    checks++;
    if (c != 0) begin
      fails++;
      $display("FAIL start_not_queued: got %0d busy cycles, want 0", c);
    end
    // Reset in the middle of RUN.
    run_len = 8'd10; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    step();
    checks++;
    if (enable !== 1'b0 || busy !== 1'b0 || runs_done !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid_run: got en=%b busy=%b runs=%0d, want 0 0 0", enable, busy, runs_done);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int en_tot = 0, done_tot = 0, bad = 0, e, d;
    run_len = 8'd1; arm_dly = 4'd0;
    for (int r = 0; r < 260; r++) begin
      e = 0; d = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (enable) e++;
        if (done) d++;
        step();
      end
      if (e != 1 || d != 1) bad++;
      en_tot += e; done_tot += d;
      if (r == 253) begin
        checks++;
        if (runs_done !== 8'hFE) begin
          fails++;
          $display("FAIL b2b_runs_254: got %h, want fe", runs_done);
        end
      end
    end
    checks++;
    if (bad != 0 || en_tot != 260 || done_tot != 260) begin
      fails++;
      $display("FAIL b2b_counts: got bad=%0d en=%0d done=%0d, want 0 260 260", bad, en_tot, done_tot);
    end
    checks++;
    if (runs_done !== 8'hFF) begin
      fails++;
      $display("FAIL b2b_saturate: got %h, want ff", runs_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_arm_delay();
    test_abort();
    test_zero_len_and_ignore();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
